// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions and MEM FSM states.
package pipe_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_LB  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;
    localparam logic [3:0] OP_SB  = 4'hB;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] opc);
        return (opc == OP_LW) || (opc == OP_LB) || (opc == OP_SW) || (opc == OP_SB);
    endfunction

    function automatic logic is_store_op(input logic [3:0] opc);
        return (opc == OP_SW) || (opc == OP_SB);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// 16-bit data RAM: synchronous byte-lane write, asynchronous read, no reset on contents.
module dmem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic [1:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [15:0]              wdata,
    output logic [15:0]              rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB register: multi-cycle data-memory access FSM and write-back registers.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] instr_in,
    input  logic [15:0] op1_in,
    input  logic [31:0] alu_result_in,
    output logic        stall_out,
    output logic        out_valid,
    output logic [15:0] instr_out,
    output logic [31:0] wb_data_out,
    output logic        wb_en_out,
    output logic [3:0]  wb_reg_out,
    output logic        addr_err_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     acc_instr_q, acc_instr_d;
    logic [15:0]     acc_data_q, acc_data_d;
    logic [AW-1:0]   acc_word_q, acc_word_d;
    logic            acc_lane_q, acc_lane_d;
    logic            acc_ok_q, acc_ok_d;

    logic            out_valid_q, out_valid_d;
    logic [15:0]     instr_out_q, instr_out_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            wb_en_q, wb_en_d;
    logic [3:0]      wb_reg_q, wb_reg_d;
    logic            addr_err_q, addr_err_d;

    logic [3:0]      in_opc, acc_opc;
    logic            in_range, commit;
    logic [1:0]      ram_we;
    logic [15:0]     ram_wdata, ram_rdata;
    logic [7:0]      ld_byte;
    logic [31:0]     ld_data;

    assign in_opc   = instr_in[OPC_HI:OPC_LO];
    assign acc_opc  = acc_instr_q[OPC_HI:OPC_LO];
    assign in_range = alu_result_in < 32'(2 * DEPTH);
    assign commit   = (state_q == ACCESS) && (cnt_q == '0);

    // Writes happen only on the commit edge, so a reset mid-access never reaches the RAM.
    always_comb begin
        ram_we    = '0;
        ram_wdata = acc_data_q;
        if (commit && acc_ok_q) begin
            if (acc_opc == OP_SW) begin
                ram_we = 2'b11;
            end else if (acc_opc == OP_SB) begin
                ram_we    = acc_lane_q ? 2'b10 : 2'b01;
                ram_wdata = {acc_data_q[7:0], acc_data_q[7:0]};
            end
        end
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_dmem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_word_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        ld_byte = acc_lane_q ? ram_rdata[15:8] : ram_rdata[7:0];
        ld_data = '0;
        if (acc_ok_q) begin
            if (acc_opc == OP_LB) ld_data = {{24{ld_byte[7]}}, ld_byte};
            else                  ld_data = {16'h0000, ram_rdata};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_instr_d = acc_instr_q;
        acc_data_d  = acc_data_q;
        acc_word_d  = acc_word_q;
        acc_lane_d  = acc_lane_q;
        acc_ok_d    = acc_ok_q;
        out_valid_d = out_valid_q;
        instr_out_d = instr_out_q;
        wb_data_d   = wb_data_q;
        wb_en_d     = wb_en_q;
        wb_reg_d    = wb_reg_q;
        addr_err_d  = addr_err_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    if (is_mem_op(in_opc)) begin
                        state_d     = ACCESS;
                        cnt_d       = CW'(MEM_LATENCY - 1);
                        acc_instr_d = instr_in;
                        acc_data_d  = op1_in;
                        acc_word_d  = alu_result_in[AW:1];
                        acc_lane_d  = alu_result_in[0];
                        acc_ok_d    = in_range;
                    end else begin
                        out_valid_d = 1'b1;
                        instr_out_d = instr_in;
                        wb_data_d   = alu_result_in;
                        wb_en_d     = (in_opc != OP_NOP);
                        wb_reg_d    = instr_in[RD_HI:RD_LO];
                        addr_err_d  = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    instr_out_d = acc_instr_q;
                    wb_data_d   = is_store_op(acc_opc) ? '0 : ld_data;
                    wb_en_d     = !is_store_op(acc_opc);
                    wb_reg_d    = acc_instr_q[RD_HI:RD_LO];
                    addr_err_d  = !acc_ok_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_instr_q <= '0;
            acc_data_q  <= '0;
            acc_word_q  <= '0;
            acc_lane_q  <= 1'b0;
            acc_ok_q    <= 1'b0;
            out_valid_q <= 1'b0;
            instr_out_q <= '0;
            wb_data_q   <= '0;
            wb_en_q     <= 1'b0;
            wb_reg_q    <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_instr_q <= acc_instr_d;
            acc_data_q  <= acc_data_d;
            acc_word_q  <= acc_word_d;
            acc_lane_q  <= acc_lane_d;
            acc_ok_q    <= acc_ok_d;
            out_valid_q <= out_valid_d;
            instr_out_q <= instr_out_d;
            wb_data_q   <= wb_data_d;
            wb_en_q     <= wb_en_d;
            wb_reg_q    <= wb_reg_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign stall_out    = (state_q == ACCESS);
    assign out_valid    = out_valid_q;
    assign instr_out    = instr_out_q;
    assign wb_data_out  = wb_data_q;
    assign wb_en_out    = wb_en_q;
    assign wb_reg_out   = wb_reg_q;
    assign addr_err_out = addr_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random ops against a byte-addressed memory model.
module tb_mem_wb_stage;

    localparam int DEPTH = 256;
    localparam int ML    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] instr_in = '0;
    logic [15:0] op1_in = '0;
    logic [31:0] alu_result_in = '0;
    logic        stall_out, out_valid, wb_en_out, addr_err_out;
    logic [15:0] instr_out;
    logic [31:0] wb_data_out;
    logic [3:0]  wb_reg_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DEPTH       (DEPTH),
        .MEM_LATENCY (ML)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .instr_in      (instr_in),
        .op1_in        (op1_in),
        .alu_result_in (alu_result_in),
        .stall_out     (stall_out),
        .out_valid     (out_valid),
        .instr_out     (instr_out),
        .wb_data_out   (wb_data_out),
        .wb_en_out     (wb_en_out),
        .wb_reg_out    (wb_reg_out),
        .addr_err_out  (addr_err_out)
    );

    function automatic logic [15:0] mk(input logic [3:0] opc, input logic [3:0] rd);
        return {opc, rd, 4'h5, 4'h6};
    endfunction

    // Reference: byte address a selects byte a of a little-endian array of 2*DEPTH bytes.
    task automatic model_op(input logic [15:0] ins, input logic [15:0] d, input logic [31:0] a,
                            output logic [31:0] data, output logic en, output logic err,
                            output logic st, output int lat);
        logic [3:0] opc;
        logic [7:0] b;
        int w;
        opc  = ins[15:12];
        err  = 1'b0;
        st   = 1'b0;
        data = a;
        en   = (opc != 4'h0);
        lat  = 1;
        if (opc >= 4'h8 && opc <= 4'hB) begin
            lat = ML + 1;
            err = (a >= 2 * DEPTH);
            st  = (opc == 4'hA || opc == 4'hB);
            en  = !st;
            w   = int'(a / 2);
            data = 0;
            if (!err) begin
                b = (a % 2 == 1) ? ref_mem[w][15:8] : ref_mem[w][7:0];
                case (opc)
                    4'h8: data = {16'h0, ref_mem[w]};
                    4'h9: data = (b >= 8'h80) ? 32'hFFFF_FF00 + b : {24'h0, b};
                    4'hA: ref_mem[w] = d;
                    default: begin
                        if (a % 2 == 1) ref_mem[w][15:8] = d[7:0];
                        else            ref_mem[w][7:0]  = d[7:0];
                    end
                endcase
            end
        end
    endtask

    // Presents one op and waits (bounded) for its completion; leaves in_valid asserted.
    task automatic drive_op(input logic [15:0] ins, input logic [15:0] d, input logic [31:0] a,
                            output int cycles, output int stalls);
        in_valid = 1'b1;
        instr_in = ins;
        op1_in = d;
        alu_result_in = a;
        cycles = 0;
        stalls = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            if (stall_out) stalls++;
        end while (!out_valid && cycles < 20);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, instr_out, wb_data_out, wb_en_out, wb_reg_out, addr_err_out, stall_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b i=%h d=%h en=%b r=%h e=%b s=%b exp all 0",
                     out_valid, instr_out, wb_data_out, wb_en_out, wb_reg_out, addr_err_out, stall_out);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nonmem();
        int c, s;
        drive_op(mk(4'h1, 4'd3), 16'h0, 32'h0001_2345, c, s);
        checks++;
        if ({c, s, out_valid, wb_data_out, wb_reg_out, wb_en_out, stall_out, instr_out} !==
            {32'd1, 32'd0, 1'b1, 32'h0001_2345, 4'd3, 1'b1, 1'b0, mk(4'h1, 4'd3)}) begin
            errors++;
            $display("FAIL add_result got c=%0d s=%0d v=%b d=%h r=%h en=%b exp c=1 s=0 v=1 d=00012345 r=3 en=1",
                     c, s, out_valid, wb_data_out, wb_reg_out, wb_en_out);
        end
        idle_cycle();
        checks++;
        if ({out_valid, wb_data_out, wb_reg_out} !== {1'b0, 32'h0001_2345, 4'd3}) begin
            errors++;
            $display("FAIL idle_hold got v=%b d=%h r=%h exp v=0 d=00012345 r=3", out_valid, wb_data_out, wb_reg_out);
        end
        drive_op(mk(4'h0, 4'd7), 16'h0, 32'h0000_0042, c, s);
        checks++;
        if ({out_valid, wb_en_out, wb_data_out} !== {1'b1, 1'b0, 32'h42}) begin
            errors++;
            $display("FAIL nop_wb_en got v=%b en=%b d=%h exp v=1 en=0 d=00000042", out_valid, wb_en_out, wb_data_out);
        end
        idle_cycle();
    endtask

    task automatic test_store_load();
        int c, s;
        logic [31:0] ed; logic een, eer, est; int el;
        model_op(mk(4'hA, 4'd1), 16'hBEEF, 32'h10, ed, een, eer, est, el);
        drive_op(mk(4'hA, 4'd1), 16'hBEEF, 32'h10, c, s);
        checks++;
        if ({c, s, out_valid, wb_en_out, addr_err_out} !== {el, ML, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sw_timing got c=%0d s=%0d v=%b en=%b e=%b exp c=%0d s=%0d v=1 en=0 e=0",
                     c, s, out_valid, wb_en_out, addr_err_out, el, ML);
        end
        model_op(mk(4'h8, 4'd2), 16'h0, 32'h10, ed, een, eer, est, el);
        drive_op(mk(4'h8, 4'd2), 16'h0, 32'h10, c, s);
        checks++;
        if ({c, wb_data_out, wb_en_out, wb_reg_out} !== {32'd3, 32'h0000_BEEF, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL lw_after_sw got c=%0d d=%h en=%b r=%h exp c=3 d=0000beef en=1 r=2",
                     c, wb_data_out, wb_en_out, wb_reg_out);
        end
        idle_cycle();
    endtask

    task automatic test_byte_ops();
        int c, s;
        logic [31:0] ed; logic een, eer, est; int el;
        model_op(mk(4'hA, 4'd0), 16'h1234, 32'h20, ed, een, eer, est, el);
        drive_op(mk(4'hA, 4'd0), 16'h1234, 32'h20, c, s);
        model_op(mk(4'hB, 4'd0), 16'h0080, 32'h21, ed, een, eer, est, el);
        drive_op(mk(4'hB, 4'd0), 16'h0080, 32'h21, c, s);
        drive_op(mk(4'h8, 4'd4), 16'h0, 32'h20, c, s);
        checks++;
        if (wb_data_out !== 32'h0000_8034) begin
            errors++;
            $display("FAIL sb_word got %h exp 00008034", wb_data_out);
        end
        drive_op(mk(4'h9, 4'd5), 16'h0, 32'h21, c, s);
        checks++;
        if (wb_data_out !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_high got %h exp ffffff80", wb_data_out);
        end
        drive_op(mk(4'h9, 4'd6), 16'h0, 32'h20, c, s);
        checks++;
        if (wb_data_out !== 32'h0000_0034) begin
            errors++;
            $display("FAIL lb_low got %h exp 00000034", wb_data_out);
        end
        idle_cycle();
    endtask

    task automatic test_out_of_range();
        int c, s;
        logic [31:0] ed; logic een, eer, est; int el;
        model_op(mk(4'hA, 4'd0), 16'hA5A5, 32'h0, ed, een, eer, est, el);
        drive_op(mk(4'hA, 4'd0), 16'hA5A5, 32'h0, c, s);
        drive_op(mk(4'hA, 4'd0), 16'h5555, 32'h200, c, s);
        checks++;
        if ({out_valid, addr_err_out, wb_en_out} !== 3'b110) begin
            errors++;
            $display("FAIL oor_sw_err got v=%b e=%b en=%b exp v=1 e=1 en=0", out_valid, addr_err_out, wb_en_out);
        end
        drive_op(mk(4'h2, 4'd9), 16'h0, 32'h77, c, s);
        checks++;
        if ({addr_err_out, wb_data_out} !== {1'b0, 32'h77}) begin
            errors++;
            $display("FAIL oor_clear got e=%b d=%h exp e=0 d=00000077", addr_err_out, wb_data_out);
        end
        drive_op(mk(4'h8, 4'd1), 16'h0, 32'h0, c, s);
        checks++;
        if ({wb_data_out, addr_err_out} !== {32'h0000_A5A5, 1'b0}) begin
            errors++;
            $display("FAIL oor_ram_kept got d=%h e=%b exp d=0000a5a5 e=0", wb_data_out, addr_err_out);
        end
        drive_op(mk(4'h8, 4'd1), 16'h0, 32'h201, c, s);
        checks++;
        if ({wb_data_out, addr_err_out} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL oor_load got d=%h e=%b exp d=00000000 e=1", wb_data_out, addr_err_out);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_access();
        int c, s;
        logic [31:0] ed; logic een, eer, est; int el;
        model_op(mk(4'hA, 4'd0), 16'h1111, 32'h30, ed, een, eer, est, el);
        drive_op(mk(4'hA, 4'd0), 16'h1111, 32'h30, c, s);
        in_valid = 1'b1;
        instr_in = mk(4'hA, 4'd0);
        op1_in = 16'h2222;
        alu_result_in = 32'h30;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, instr_out, wb_data_out, wb_en_out, wb_reg_out, addr_err_out, stall_out} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%b d=%h en=%b s=%b exp all 0", out_valid, wb_data_out, wb_en_out, stall_out);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({stall_out, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_idle got s=%b v=%b exp s=0 v=0", stall_out, out_valid);
        end
        drive_op(mk(4'h8, 4'd3), 16'h0, 32'h30, c, s);
        checks++;
        if ({c, wb_data_out} !== {32'd3, 32'h0000_1111}) begin
            errors++;
            $display("FAIL rst_mid_ram got c=%0d d=%h exp c=3 d=00001111", c, wb_data_out);
        end
        idle_cycle();
    endtask

    task automatic test_stall_hold();
        int c;
        in_valid = 1'b1;
        instr_in = mk(4'h8, 4'd6);
        op1_in = 16'h0;
        alu_result_in = 32'h10;
        @(posedge clk); #1;
        instr_in = mk(4'h3, 4'd9);
        alu_result_in = 32'h20;
        op1_in = 16'hFFFF;
        c = 1;
        while (!out_valid && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if ({c, instr_out, wb_data_out, wb_reg_out} !== {32'd3, mk(4'h8, 4'd6), 32'h0000_BEEF, 4'd6}) begin
            errors++;
            $display("FAIL stall_hold got c=%0d i=%h d=%h r=%h exp c=3 i=%h d=0000beef r=6",
                     c, instr_out, wb_data_out, wb_reg_out, mk(4'h8, 4'd6));
        end
        idle_cycle();
    endtask

    task automatic test_random();
        int c, s, el;
        logic [31:0] ed, a, got_d;
        logic een, eer, est;
        logic [3:0] opc;
        logic [15:0] ins, d;
        for (int unsigned w = 0; w < 16; w++) begin
            d = 16'($urandom());
            model_op(mk(4'hA, 4'd0), d, 32'(w * 2), ed, een, eer, est, el);
            drive_op(mk(4'hA, 4'd0), d, 32'(w * 2), c, s);
        end
        for (int unsigned n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                opc = 4'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) opc = 4'($urandom_range(12, 15));
                a = $urandom();
            end else begin
                opc = 4'(8 + $urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = 32'd512 + $urandom_range(0, 100000);
                else                           a = $urandom_range(0, 31);
            end
            ins = {opc, 4'($urandom_range(0, 15)), 8'($urandom())};
            d = 16'($urandom());
            model_op(ins, d, a, ed, een, eer, est, el);
            drive_op(ins, d, a, c, s);
            got_d = est ? 32'h0 : wb_data_out;
            checks++;
            if ({c, s} !== {el, (el == 1) ? 32'd0 : ML}) begin
                errors++;
                $display("FAIL rand_timing op=%h got c=%0d s=%0d exp c=%0d", ins, c, s, el);
            end
            checks++;
            if ({out_valid, instr_out, got_d, wb_en_out, wb_reg_out, addr_err_out} !==
                {1'b1, ins, est ? 32'h0 : ed, een, ins[11:8], eer}) begin
                errors++;
                $display("FAIL rand_result op=%h a=%h got d=%h en=%b r=%h e=%b exp d=%h en=%b e=%b",
                         ins, a, got_d, wb_en_out, wb_reg_out, addr_err_out, ed, een, eer);
            end
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle got v=%b exp 0", out_valid);
                end
            end
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_store_load();
        test_byte_ops();
        test_out_of_range();
        test_reset_mid_access();
        test_stall_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
